// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared state encodings, handshake constants and widths for the divider
package div_ctrl_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_RES_W = 2 * DIV_WIDTH;
  localparam int DIV_CNT_W = 6;
  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;
  localparam logic DIV_START     = 1'b1;
  localparam logic DIV_STOP      = 1'b0;
  localparam logic DIV_READY     = 1'b1;
  localparam logic DIV_NOT_READY = 1'b0;
endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: EX-stage request/response bundle between the pipeline and the divider
interface div_ctrl_if #(parameter int WIDTH = 32);
  logic               start;
  logic               signed_div;
  logic               annul;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               stall;
  modport master (output start, signed_div, annul, opdata1, opdata2, input result, ready, stall);
  modport slave  (input start, signed_div, annul, opdata1, opdata2, output result, ready, stall);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift in next dividend bit, trial-subtract divisor)
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] upper;
  logic [WIDTH:0] diff;
  // rem_i < dvs_i always, so the shifted upper part fits in WIDTH+1 bits
  assign upper = {rem_i, quo_i[WIDTH-1]};
  assign diff  = upper - {1'b0, dvs_i};
  assign rem_o = diff[WIDTH] ? upper[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU controller, 32-step restoring division with sign fix-up
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input logic   clk,
  input logic   resetn,
  div_ctrl_if.slave bus
);
  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               neg1, neg2;
  logic [WIDTH-1:0]   mag1, mag2, step_rem, step_quo;
  assign neg1 = bus.signed_div & bus.opdata1[WIDTH-1];
  assign neg2 = bus.signed_div & bus.opdata2[WIDTH-1];
  assign mag1 = neg1 ? -bus.opdata1 : bus.opdata1;
  assign mag2 = neg2 ? -bus.opdata2 : bus.opdata2;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(step_rem),
    .quo_o(step_quo)
  );
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = DIV_NOT_READY;
    case (state_q)
      DIV_IDLE: begin
        // ready_q guard keeps a start still high in the ready cycle from re-launching
        if (bus.start == DIV_START && !bus.annul && !ready_q) begin
          if (bus.opdata2 == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d = DIV_ON;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = mag1;
            dvs_d   = mag2;
            qneg_d  = neg1 ^ neg2;
            rneg_d  = neg1;
          end
        end
      end
      DIV_BYZERO: begin
        if (bus.annul) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d    = '0;
          quo_d    = '0;
          qneg_d   = 1'b0;
          rneg_d   = 1'b0;
          result_d = '0;
          state_d  = DIV_END;
        end
      end
      DIV_ON: begin
        if (bus.annul) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? DIV_END : DIV_ON;
        end
      end
      default: begin
        result_d = {rneg_q ? -rem_q : rem_q, qneg_q ? -quo_q : quo_q};
        ready_d  = DIV_READY;
        state_d  = DIV_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_NOT_READY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end
  assign bus.result = result_q;
  assign bus.ready  = ready_q;
  assign bus.stall  = bus.start & ~ready_q;
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed plus random DIV/DIVU runs checked against an integer-arithmetic model
module tb_div_ctrl;
  localparam int W = 32;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  div_ctrl_if #(.WIDTH(W)) bus ();
  div_ctrl #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint x, y, q, r;
    logic [63:0] qv, rv;
    if (b == '0) return '0;
    x = s ? longint'($signed(a)) : longint'({32'b0, a});
    y = s ? longint'($signed(b)) : longint'({32'b0, b});
    q = x / y;
    r = x % y;
    qv = q;
    rv = r;
    return {rv[W-1:0], qv[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Latency is counted in clock edges after the edge that samples start
  task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [2*W-1:0] exp;
    int n;
    logic stall_ok;
    exp = ref_div(a, b, s);
    bus.annul = 1'b0;
    bus.start = 1'b1;
    bus.signed_div = s;
    bus.opdata1 = a;
    bus.opdata2 = b;
    @(posedge clk);
    #1;
    bus.opdata1 = $urandom;
    bus.opdata2 = $urandom;
    bus.signed_div = ~s;
    n = 0;
    stall_ok = 1'b1;
    while (!bus.ready && n < 100) begin
      stall_ok &= bus.stall;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), (b == '0) ? 64'd2 : 64'(W + 1));
    check({tag, " stall_busy"}, 64'(stall_ok), 64'd1);
    check({tag, " result"}, 64'(bus.result), 64'(exp));
    check({tag, " stall_in_ready"}, 64'(bus.stall), 64'd0);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " ready_pulse"}, 64'(bus.ready), 64'd0);
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    logic rs;
    bus.start = 1'b0;
    bus.signed_div = 1'b0;
    bus.annul = 1'b0;
    bus.opdata1 = '0;
    bus.opdata2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 64'(bus.ready), 64'd0);
    check("reset result", 64'(bus.result), 64'd0);
    check("reset stall", 64'(bus.stall), 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    do_div("divu_100_7", 32'd100, 32'd7, 1'b0);
    check("divu_100_7 const", 64'(bus.result), {32'h2, 32'hE});
    do_div("div_m7_2", 32'hFFFFFFF9, 32'h2, 1'b1);
    check("div_m7_2 const", 64'(bus.result), {32'hFFFFFFFF, 32'hFFFFFFFD});
    do_div("divu_max_1", 32'hFFFFFFFF, 32'h1, 1'b0);
    do_div("div_m1_1", 32'hFFFFFFFF, 32'h1, 1'b1);
    do_div("div_by_zero", 32'h1234, 32'h0, 1'b0);
    // annul mid-ON: no ready may appear afterwards
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd50;
    bus.opdata2 = 32'd5;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready) seen++;
    end
    check("annul no_ready", 64'(seen), 64'd0);
    do_div("after_annul_9_3", 32'd9, 32'd3, 1'b0);
    // annul held in IDLE must block acceptance; do_div then measures full latency
    bus.start = 1'b1;
    bus.annul = 1'b1;
    bus.opdata1 = 32'd77;
    bus.opdata2 = 32'd4;
    repeat (3) @(posedge clk);
    #1;
    check("annul_idle stall", 64'(bus.stall), 64'd1);
    do_div("after_idle_annul", 32'd77, 32'd4, 1'b0);
    do_div("pre_reset", 32'd9, 32'd3, 1'b0);
    bus.start = 1'b1;
    bus.opdata1 = 32'd1000;
    bus.opdata2 = 32'd3;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("midreset ready", 64'(bus.ready), 64'd0);
    check("midreset result", 64'(bus.result), 64'd0);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready) seen++;
    end
    check("midreset no_ready", 64'(seen), 64'd0);
    do_div("div_overflow", 32'h80000000, 32'hFFFFFFFF, 1'b1);
    check("div_overflow const", 64'(bus.result), {32'h0, 32'h80000000});
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? '0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 1000)));
      rs = 1'($urandom_range(0, 1));
      do_div($sformatf("rand%0d", i), ra, rb, rs);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
